// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the multi-channel reset / clock-enable sequencer.
// The next-channel search is a plain function so it can be reused outside the RTL.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATED,
        RUN_PRE,
        RELEASE
    } seq_state_t;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_GATE_CYCLES = 50;
    localparam int DEF_RUN_CYCLES  = 50;
    localparam int DEF_STAGGER     = 4;

    localparam int         MAX_CH = 32;
    localparam logic [5:0] NO_CH  = 6'd32;

    // Lowest set bit of mask strictly above 'after'; NO_CH when there is none.
    function automatic logic [5:0] lowest_set_above(input logic [MAX_CH-1:0] mask,
                                                    input int                after);
        logic [5:0] pos;
        pos = NO_CH;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > after)) begin
                pos = 6'(i);
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/rst_seq_next_ch.sv
// Combinational search for the next channel to release above a given index,
// plus a flag telling whether that channel is the last one left in the mask.
module rst_seq_next_ch
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_from_start,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_none
);

    logic [MAX_CH-1:0] w_mask_ext;
    logic [5:0]        w_pos;
    logic [5:0]        w_after_pos;

    always_comb begin
        w_mask_ext             = '0;
        w_mask_ext[NUM_CH-1:0] = i_mask;
        w_pos                  = lowest_set_above(w_mask_ext, i_from_start ? -1 : int'(i_idx));
        w_after_pos            = lowest_set_above(w_mask_ext, int'(w_pos));
    end

    assign o_idx  = w_pos[IDX_W-1:0];
    assign o_none = (w_after_pos == NO_CH);

endmodule

// File: rtl/rst_seq_gen.sv
// Multi-channel reset and clock-enable sequencer: gate, run under reset, then
// release channels in ascending order with a fixed stagger; supports re-reset requests.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int RUN_CYCLES  = DEF_RUN_CYCLES,
    parameter int STAGGER     = DEF_STAGGER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rst_req,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic [NUM_CH-1:0] clk_en,
    output logic              busy,
    output logic              done
);

    localparam int     IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam longint CNT_LIM = longint'(1) << CNT_W;

    generate
        if (NUM_CH < 1 || NUM_CH > MAX_CH ||
            GATE_CYCLES < 1 || longint'(GATE_CYCLES) >= CNT_LIM ||
            RUN_CYCLES < 1  || longint'(RUN_CYCLES)  >= CNT_LIM ||
            STAGGER < 1     || longint'(STAGGER)     >= CNT_LIM) begin : g_param_check
            $error("rst_seq_gen: NUM_CH must be 1..32 and phase lengths 1..2^CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] GATE_LD = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LD  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LD = CNT_W'(STAGGER - 1);

    seq_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_CH-1:0] r_active;
    logic [NUM_CH-1:0] r_pending;
    logic [IDX_W-1:0]  r_idx;
    logic [NUM_CH-1:0] r_rst_n;
    logic [NUM_CH-1:0] r_clk_en;
    logic              r_busy;
    logic              r_done;

    seq_state_t        w_state;
    logic [CNT_W-1:0]  w_cnt;
    logic [NUM_CH-1:0] w_active;
    logic [NUM_CH-1:0] w_pending;
    logic [IDX_W-1:0]  w_idx;
    logic [NUM_CH-1:0] w_rst_n;
    logic [NUM_CH-1:0] w_clk_en;
    logic              w_busy;
    logic              w_done;
    logic              w_req;
    logic [NUM_CH-1:0] w_start_mask;
    logic              w_from_start;
    logic [IDX_W-1:0]  w_sel;
    logic              w_last;

    assign w_req        = rst_req && (ch_mask != '0);
    assign w_from_start = (r_state == RUN_PRE);

    rst_seq_next_ch #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_next_ch (
        .i_mask       (r_active),
        .i_idx        (r_idx),
        .i_from_start (w_from_start),
        .o_idx        (w_sel),
        .o_none       (w_last)
    );

    // Reset lands directly in the first GATED cycle of an all-channel sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= GATED;
            r_cnt     <= GATE_LD;
            r_active  <= '1;
            r_pending <= '0;
            r_idx     <= '0;
            r_rst_n   <= '0;
            r_clk_en  <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_active  <= w_active;
            r_pending <= w_pending;
            r_idx     <= w_idx;
            r_rst_n   <= w_rst_n;
            r_clk_en  <= w_clk_en;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_active     = r_active;
        w_pending    = r_pending;
        w_idx        = r_idx;
        w_rst_n      = r_rst_n;
        w_clk_en     = r_clk_en;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_start_mask = r_pending | (w_req ? ch_mask : '0);

        if ((r_state != IDLE) && w_req) begin
            w_pending = r_pending | ch_mask;
        end

        case (r_state)
            IDLE: begin
                // Pending work left by the previous sequence merges with a fresh request.
                if (w_start_mask != '0) begin
                    w_state   = GATED;
                    w_cnt     = GATE_LD;
                    w_active  = w_start_mask;
                    w_pending = '0;
                    w_rst_n   = r_rst_n & ~w_start_mask;
                    w_clk_en  = r_clk_en & ~w_start_mask;
                    w_busy    = 1'b1;
                end
            end
            GATED: begin
                if (r_cnt == '0) begin
                    w_state  = RUN_PRE;
                    w_cnt    = RUN_LD;
                    w_clk_en = r_clk_en | r_active;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            RUN_PRE, RELEASE: begin
                if (r_cnt == '0) begin
                    w_rst_n[w_sel] = 1'b1;
                    w_idx          = w_sel;
                    w_cnt          = STAG_LD;
                    if (w_last) begin
                        w_state = IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_state = RELEASE;
                    end
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign rst_n_out = r_rst_n;
    assign clk_en    = r_clk_en;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Self-checking bench: a short-phase instance checked against a schedule-based model,
// plus a default-parameter instance checked for the power-on timing.
module tb_rst_seq_gen;

    localparam int N = 4;
    localparam int G = 3;
    localparam int R = 2;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rstReq = 1'b0;
    logic [N-1:0] chMask = '0;
    logic [N-1:0] rstNOut;
    logic [N-1:0] clkEn;
    logic         busy;
    logic         done;

    logic         dReset = 1'b1;
    logic         dReq = 1'b0;
    logic [N-1:0] dMask = '0;
    logic [N-1:0] dRstNOut;
    logic [N-1:0] dClkEn;
    logic         dBusy;
    logic         dDone;

    int nVec = 0;
    int nErr = 0;
    int cyc = 0;
    int c0 = 0;

    // Model state: the current sequence is described by its start cycle and release times.
    bit           mSeq = 1'b0;
    int           mStart = 0;
    int           mLast = 0;
    int           mRel[N];
    logic [N-1:0] mMask = '0;
    logic [N-1:0] mPend = '0;
    logic [N-1:0] mRstN = '0;
    logic [N-1:0] mClkEn = '0;
    logic         mBusy = 1'b1;
    logic         mDone = 1'b0;

    always #5 clk = ~clk;

    rst_seq_gen #(
        .NUM_CH      (N),
        .CNT_W       (8),
        .GATE_CYCLES (G),
        .RUN_CYCLES  (R),
        .STAGGER     (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rst_req   (rstReq),
        .ch_mask   (chMask),
        .rst_n_out (rstNOut),
        .clk_en    (clkEn),
        .busy      (busy),
        .done      (done)
    );

    rst_seq_gen dutDef (
        .clk       (clk),
        .reset     (dReset),
        .rst_req   (dReq),
        .ch_mask   (dMask),
        .rst_n_out (dRstNOut),
        .clk_en    (dClkEn),
        .busy      (dBusy),
        .done      (dDone)
    );

    task automatic modelStart(input logic [N-1:0] m);
        int k;
        k      = 0;
        mSeq   = 1'b1;
        mStart = cyc;
        mMask  = m;
        mRstN  = mRstN & ~m;
        mClkEn = mClkEn & ~m;
        mBusy  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                mRel[i] = cyc + G + R + k * S;
                mLast   = mRel[i];
                k++;
            end else begin
                mRel[i] = -1;
            end
        end
    endtask

    task automatic modelStep(input logic r, input logic q, input logic [N-1:0] m);
        logic [N-1:0] t;
        mDone = 1'b0;
        if (r) begin
            mPend  = '0;
            mRstN  = '0;
            mClkEn = '0;
            modelStart('1);
        end else if (!mSeq) begin
            t = mPend | (q ? m : '0);
            if (t != '0) begin
                mPend = '0;
                modelStart(t);
            end
        end else begin
            if (q && (m != '0)) mPend = mPend | m;
            if (cyc == mStart + G) mClkEn = mClkEn | mMask;
            for (int i = 0; i < N; i++) begin
                if (mRel[i] == cyc) mRstN[i] = 1'b1;
            end
            if (cyc == mLast) begin
                mDone = 1'b1;
                mBusy = 1'b0;
                mSeq  = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic         sR;
        logic         sQ;
        logic [N-1:0] sM;
        sR = reset;
        sQ = rstReq;
        sM = chMask;
        @(posedge clk);
        #1;
        cyc++;
        modelStep(sR, sQ, sM);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        dReset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nVec++;
            if ({rstNOut, clkEn, busy, done} !== {mRstN, mClkEn, mBusy, mDone}) begin
                nErr++;
                $display("[TB] FAIL reset cyc=%0d got rst_n=%b clk_en=%b busy=%b done=%b want %b %b %b %b",
                         cyc, rstNOut, clkEn, busy, done, mRstN, mClkEn, mBusy, mDone);
            end
            nVec++;
            if ({dRstNOut, dClkEn, dBusy, dDone} !== {4'b0000, 4'b0000, 1'b1, 1'b0}) begin
                nErr++;
                $display("[TB] FAIL reset_default cyc=%0d got rst_n=%b clk_en=%b busy=%b done=%b want 0000 0000 1 0",
                         cyc, dRstNOut, dClkEn, dBusy, dDone);
            end
        end
        reset  = 1'b0;
        dReset = 1'b0;
        c0     = cyc;
    endtask

    task automatic test_power_on();
        int           c;
        logic [N-1:0] eRst;
        logic [N-1:0] eClk;
        for (int n = 0; n < 130; n++) begin
            tick();
            c    = cyc - c0;
            eClk = (c >= 50) ? 4'hF : 4'h0;
            for (int i = 0; i < N; i++) eRst[i] = (c >= 100 + 4 * i);
            nVec++;
            if ({dRstNOut, dClkEn, dBusy, dDone} !== {eRst, eClk, (c < 112), (c == 112)}) begin
                nErr++;
                $display("[TB] FAIL power_on_default c=%0d got rst_n=%b clk_en=%b busy=%b done=%b want %b %b %b %b",
                         c, dRstNOut, dClkEn, dBusy, dDone, eRst, eClk, (c < 112), (c == 112));
            end
            nVec++;
            if ({rstNOut, clkEn, busy, done} !== {mRstN, mClkEn, mBusy, mDone}) begin
                nErr++;
                $display("[TB] FAIL power_on cyc=%0d got rst_n=%b clk_en=%b busy=%b done=%b want %b %b %b %b",
                         cyc, rstNOut, clkEn, busy, done, mRstN, mClkEn, mBusy, mDone);
            end
        end
    endtask

    task automatic test_partial();
        int b;
        int rel;
        b = cyc;
        for (int n = 0; n < 30; n++) begin
            rel = cyc - b;
            rstReq = (rel == 10);
            chMask = (rel == 10) ? 4'b0101 : 4'b0000;
            tick();
            rel = cyc - b;
            nVec++;
            if ({rstNOut, clkEn, busy, done} !== {mRstN, mClkEn, mBusy, mDone}) begin
                nErr++;
                $display("[TB] FAIL partial cyc=%0d got rst_n=%b clk_en=%b busy=%b done=%b want %b %b %b %b",
                         cyc, rstNOut, clkEn, busy, done, mRstN, mClkEn, mBusy, mDone);
            end
            if (rel == 11 || rel == 14 || rel == 16 || rel == 18) begin
                logic [9:0] e;
                case (rel)
                    11:      e = {4'b1010, 4'b1010, 1'b1, 1'b0};
                    14:      e = {4'b1010, 4'b1111, 1'b1, 1'b0};
                    16:      e = {4'b1011, 4'b1111, 1'b1, 1'b0};
                    default: e = {4'b1111, 4'b1111, 1'b0, 1'b1};
                endcase
                nVec++;
                if ({rstNOut, clkEn, busy, done} !== e) begin
                    nErr++;
                    $display("[TB] FAIL partial_t%0d got %b want %b", rel, {rstNOut, clkEn, busy, done}, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int b;
        int rel;
        b = cyc;
        for (int n = 0; n < 35; n++) begin
            rel = cyc - b;
            rstReq = (rel == 10) || (rel == 13);
            chMask = (rel == 10) ? 4'b0101 : ((rel == 13) ? 4'b1000 : 4'b0000);
            tick();
            rel = cyc - b;
            nVec++;
            if ({rstNOut, clkEn, busy, done} !== {mRstN, mClkEn, mBusy, mDone}) begin
                nErr++;
                $display("[TB] FAIL back_to_back cyc=%0d got rst_n=%b clk_en=%b busy=%b done=%b want %b %b %b %b",
                         cyc, rstNOut, clkEn, busy, done, mRstN, mClkEn, mBusy, mDone);
            end
            if (rel == 18 || rel == 19 || rel == 22 || rel == 24) begin
                logic [9:0] e;
                case (rel)
                    18:      e = {4'b1111, 4'b1111, 1'b0, 1'b1};
                    19:      e = {4'b0111, 4'b0111, 1'b1, 1'b0};
                    22:      e = {4'b0111, 4'b1111, 1'b1, 1'b0};
                    default: e = {4'b1111, 4'b1111, 1'b0, 1'b1};
                endcase
                nVec++;
                if ({rstNOut, clkEn, busy, done} !== e) begin
                    nErr++;
                    $display("[TB] FAIL back_to_back_t%0d got %b want %b", rel, {rstNOut, clkEn, busy, done}, e);
                end
            end
        end
    endtask

    task automatic test_zero_mask();
        for (int n = 0; n < 6; n++) begin
            rstReq = 1'b1;
            chMask = 4'b0000;
            tick();
            nVec++;
            if ({rstNOut, clkEn, busy, done} !== {4'b1111, 4'b1111, 1'b0, 1'b0}) begin
                nErr++;
                $display("[TB] FAIL zero_mask cyc=%0d got rst_n=%b clk_en=%b busy=%b done=%b want 1111 1111 0 0",
                         cyc, rstNOut, clkEn, busy, done);
            end
        end
        rstReq = 1'b0;
    endtask

    task automatic test_reset_mid();
        int b;
        int rel;
        b = cyc;
        for (int n = 0; n < 35; n++) begin
            rel = cyc - b;
            reset  = (rel == 15);
            rstReq = (rel == 10) || (rel == 13);
            chMask = (rel == 10) ? 4'b0101 : ((rel == 13) ? 4'b1000 : 4'b0000);
            tick();
            rel = cyc - b;
            nVec++;
            if ({rstNOut, clkEn, busy, done} !== {mRstN, mClkEn, mBusy, mDone}) begin
                nErr++;
                $display("[TB] FAIL reset_mid cyc=%0d got rst_n=%b clk_en=%b busy=%b done=%b want %b %b %b %b",
                         cyc, rstNOut, clkEn, busy, done, mRstN, mClkEn, mBusy, mDone);
            end
            if (rel == 16 || rel == 19 || rel == 21 || rel == 27 || rel == 30) begin
                logic [9:0] e;
                case (rel)
                    16:      e = {4'b0000, 4'b0000, 1'b1, 1'b0};
                    19:      e = {4'b0000, 4'b1111, 1'b1, 1'b0};
                    21:      e = {4'b0001, 4'b1111, 1'b1, 1'b0};
                    27:      e = {4'b1111, 4'b1111, 1'b0, 1'b1};
                    default: e = {4'b1111, 4'b1111, 1'b0, 1'b0};
                endcase
                nVec++;
                if ({rstNOut, clkEn, busy, done} !== e) begin
                    nErr++;
                    $display("[TB] FAIL reset_mid_t%0d got %b want %b", rel, {rstNOut, clkEn, busy, done}, e);
                end
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 2000; n++) begin
            reset  = ($urandom_range(0, 399) == 0);
            rstReq = ($urandom_range(0, 7) == 0);
            chMask = 4'($urandom_range(0, 15));
            tick();
            nVec++;
            if ({rstNOut, clkEn, busy, done} !== {mRstN, mClkEn, mBusy, mDone}) begin
                nErr++;
                $display("[TB] FAIL random cyc=%0d got rst_n=%b clk_en=%b busy=%b done=%b want %b %b %b %b",
                         cyc, rstNOut, clkEn, busy, done, mRstN, mClkEn, mBusy, mDone);
            end
        end
        reset  = 1'b0;
        rstReq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_partial();
        test_back_to_back();
        test_zero_mask();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
